// File: rtl/seq_detector_param_pkg.sv
// seqdet_pkg: constants and helpers shared by the seq_detector_param slice.
//   OVL_ON / OVL_OFF : values for the OVERLAP parameter
//   MAX_PAT_LEN      : largest supported pattern length
//   clog2()          : ceiling log2 (minimum 1), sizes the fill counter
package seqdet_pkg;

    localparam int OVL_OFF     = 0;
    localparam int OVL_ON      = 1;
    localparam int MAX_PAT_LEN = 16;

    function automatic int clog2(input int value);
        int result;
        result = 1;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// seq_detector_param_if: serial stream and match result of the detector.
//   x, in_valid, clear : stream bit, sample qualifier, synchronous flush
//   y, match_count     : registered match flag and saturating match count
// master drives the stream; slave is the detector.
interface seq_detector_param_if #(
    parameter int COUNT_W = 8
);
    logic               x;
    logic               in_valid;
    logic               clear;
    logic               y;
    logic [COUNT_W-1:0] match_count;

    modport master (
        output x, in_valid, clear,
        input  y, match_count
    );

    modport slave (
        input  x, in_valid, clear,
        output y, match_count
    );
endinterface

// File: rtl/seq_detector_param_window.sv
// seqdet_window: sample history plus fill counter for the detector.
//   clk, rst : clock, asynchronous active-high reset
//   shift_en : accept din into the history this cycle
//   din      : serial bit
//   flush    : clear history and fill (wins over shift_en)
//   drop     : on a shift, restart the fill count (non-overlap restart)
//   win      : look-ahead window, i.e. history with din appended (newest in LSB)
//   full     : shifting din now would complete a full PAT_LEN-bit window
// Exposing the look-ahead lets the top compare and register y in one cycle.
module seqdet_window
    import seqdet_pkg::*;
#(
    parameter int PAT_LEN = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shift_en,
    input  logic               din,
    input  logic               flush,
    input  logic               drop,
    output logic [PAT_LEN-1:0] win,
    output logic               full
);
    localparam int FW = clog2(PAT_LEN + 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(PAT_LEN);

    logic [FW-1:0] fill_reg;
    logic [FW-1:0] fill_next;

    // Fill after accepting one more bit, saturating at PAT_LEN.
    assign fill_next = (fill_reg == FILL_MAX) ? fill_reg : fill_reg + 1'b1;
    assign full      = (fill_next == FILL_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_reg <= '0;
        end else if (flush) begin
            fill_reg <= '0;
        end else if (shift_en) begin
            fill_reg <= drop ? '0 : fill_next;
        end
    end

    generate
        if (PAT_LEN == 1) begin : g_single
            // A one-bit pattern needs no stored history.
            assign win = din;
        end else begin : g_hist
            // Only PAT_LEN-1 bits are kept; the oldest falls out on the shift.
            logic [PAT_LEN-2:0] hist_reg;

            assign win = {hist_reg, din};

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hist_reg <= '0;
                end else if (flush) begin
                    hist_reg <= '0;
                end else if (shift_en) begin
                    hist_reg <= win[PAT_LEN-2:0];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: parametrised Moore serial pattern detector.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : seq_detector_param_if.slave (x, in_valid, clear in; y, match_count out)
// y goes high for the sample after the final pattern bit is accepted and holds
// through in_valid=0 cycles. Build option SEQDET_COUNT_EN enables the
// saturating match counter; otherwise match_count is tied to zero.
module seq_detector_param
    import seqdet_pkg::*;
#(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1010,
    parameter int                 OVERLAP = OVL_ON,
    parameter int                 COUNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_detector_param_if.slave  bus
);
    generate
        if (PAT_LEN < 1 || PAT_LEN > MAX_PAT_LEN) begin : g_bad_len
            $error("seq_detector_param: PAT_LEN must be in 1..16");
        end
    endgenerate

    logic               sample;
    logic               hit;
    logic               drop;
    logic               full;
    logic [PAT_LEN-1:0] win;
    logic               y_reg;

    // clear has priority, so a clearing cycle never shifts or hits.
    assign sample = bus.in_valid && !bus.clear;
    assign hit    = sample && full && (win == PATTERN);
    // Non-overlap mode forces the next match to use entirely fresh bits.
    assign drop   = (OVERLAP == OVL_OFF) && hit;

    seqdet_window #(
        .PAT_LEN (PAT_LEN)
    ) u_window (
        .clk      (clk),
        .rst      (rst),
        .shift_en (sample),
        .din      (bus.x),
        .flush    (bus.clear),
        .drop     (drop),
        .win      (win),
        .full     (full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_reg <= 1'b0;
        end else if (bus.clear) begin
            y_reg <= 1'b0;
        end else if (bus.in_valid) begin
            y_reg <= hit;
        end
    end

    assign bus.y = y_reg;

`ifdef SEQDET_COUNT_EN
    logic [COUNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (bus.clear) begin
            count_reg <= '0;
        end else if (hit && (count_reg != {COUNT_W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign bus.match_count = count_reg;
`else
    assign bus.match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed scoreboard bench for seq_detector_param. Four instances cover
// overlap, non-overlap, a 2-bit saturating counter and a 1-bit pattern.
// Each driven cycle queues its hand-computed expectation; the monitor pops
// and compares just after the following clock edge.
module tb_seq_detector_param;

`ifdef SEQDET_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk;
    logic rst;

    seq_detector_param_if #(.COUNT_W(8)) if0 ();
    seq_detector_param_if #(.COUNT_W(8)) if1 ();
    seq_detector_param_if #(.COUNT_W(2)) if2 ();
    seq_detector_param_if #(.COUNT_W(8)) if3 ();

    seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1010), .OVERLAP(1), .COUNT_W(8))
        u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1010), .OVERLAP(0), .COUNT_W(8))
        u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1010), .OVERLAP(1), .COUNT_W(2))
        u2 (.clk(clk), .rst(rst), .bus(if2.slave));
    seq_detector_param #(.PAT_LEN(1), .PATTERN(1'b1), .OVERLAP(1), .COUNT_W(8))
        u3 (.clk(clk), .rst(rst), .bus(if3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int sel;
        int id;
        bit y;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    logic       y_w   [4];
    logic [7:0] cnt_w [4];

    assign y_w[0]   = if0.y;
    assign y_w[1]   = if1.y;
    assign y_w[2]   = if2.y;
    assign y_w[3]   = if3.y;
    assign cnt_w[0] = if0.match_count;
    assign cnt_w[1] = if1.match_count;
    assign cnt_w[2] = {6'd0, if2.match_count};
    assign cnt_w[3] = if3.match_count;

    task automatic idle_all();
        if0.x = 1'b0; if0.in_valid = 1'b0; if0.clear = 1'b0;
        if1.x = 1'b0; if1.in_valid = 1'b0; if1.clear = 1'b0;
        if2.x = 1'b0; if2.in_valid = 1'b0; if2.clear = 1'b0;
        if3.x = 1'b0; if3.in_valid = 1'b0; if3.clear = 1'b0;
    endtask

    // One cycle of stimulus to instance sel, with the expected y and
    // match_count after the next clock edge.
    task automatic step(input int sel, input bit xv, input bit v, input bit c,
                        input bit ey, input int ecnt);
        exp_t e;
        @(posedge clk);
        #2;
        idle_all();
        case (sel)
            0: begin if0.x = xv; if0.in_valid = v; if0.clear = c; end
            1: begin if1.x = xv; if1.in_valid = v; if1.clear = c; end
            2: begin if2.x = xv; if2.in_valid = v; if2.clear = c; end
            default: begin if3.x = xv; if3.in_valid = v; if3.clear = c; end
        endcase
        e.sel = sel;
        e.id  = step_id;
        e.y   = ey;
        e.cnt = ecnt;
        step_id = step_id + 1;
        exp_q.push_back(e);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic rst_pulse();
        @(posedge clk);
        #2;
        idle_all();
        rst = 1'b1;
        #5;
        rst = 1'b0;
    endtask

    // Monitor: compare the outputs of the instance named by each queued item.
    initial begin
        exp_t e;
        int   want_cnt;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                want_cnt = CNT_EN ? e.cnt : 0;
                checks = checks + 1;
                if (y_w[e.sel] !== e.y) begin
                    errors = errors + 1;
                    $display("FAIL y dut%0d step%0d got %0b want %0b",
                             e.sel, e.id, y_w[e.sel], e.y);
                end
                checks = checks + 1;
                if (cnt_w[e.sel] !== 8'(want_cnt)) begin
                    errors = errors + 1;
                    $display("FAIL match_count dut%0d step%0d got %0d want %0d",
                             e.sel, e.id, cnt_w[e.sel], want_cnt);
                end
                $display("step%0d dut%0d y=%0b count=%0d", e.id, e.sel,
                         y_w[e.sel], cnt_w[e.sel]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle_all();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        // Reset state of every instance.
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(2, 0, 0, 0, 0, 0);
        step(3, 0, 0, 0, 0, 0);

        // Overlapping 1,0,1,0,1,0: hits after bits 4 and 6.
        step(0, 1, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 0, 1, 0, 1, 1);
        step(0, 1, 1, 0, 0, 1);
        step(0, 0, 1, 0, 1, 2);

        // Non-overlapping 1,0,1,0,1,0,1,0: hits after bits 4 and 8 only.
        step(1, 1, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        step(1, 0, 1, 0, 1, 1);
        step(1, 1, 1, 0, 0, 1);
        step(1, 0, 1, 0, 0, 1);
        step(1, 1, 1, 0, 0, 1);
        step(1, 0, 1, 0, 1, 2);

        // in_valid gaps: 3-cycle gap mid-pattern, then y holds over a 2-cycle gap.
        step(0, 0, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 0, 1, 0, 1, 1);
        step(0, 0, 0, 0, 1, 1);
        step(0, 1, 0, 0, 1, 1);

        // 1,0,1 then reset then 0: partial progress discarded.
        step(0, 0, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        rst_pulse();
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        // 1,0,1,0 afterwards matches.
        step(0, 1, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 0, 1, 0, 1, 1);
        // Clear coinciding with the 4th bit suppresses the hit.
        step(0, 0, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        // Clear also set y low after a hold; fresh 1,0,1,0 matches again.
        step(0, 1, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 0, 1, 0, 1, 1);

        // COUNT_W=2: five overlapping hits, count saturates at 3.
        for (int i = 0; i < 12; i++) begin
            bit xb;
            bit ey;
            int ec;
            xb = (i % 2 == 0);
            ey = (i >= 3) && (i % 2 == 1);
            ec = (i < 3) ? 0 : ((i + 1) / 2 - 1 > 3 ? 3 : (i + 1) / 2 - 1);
            step(2, xb, 1, 0, ey, ec);
        end

        // PAT_LEN=1, PATTERN=1: x=1,1,0,1 hits after bits 1, 2 and 4.
        step(3, 1, 1, 0, 1, 1);
        step(3, 1, 1, 0, 1, 2);
        step(3, 0, 1, 0, 0, 2);
        step(3, 1, 1, 0, 1, 3);

        @(posedge clk);
        #2;
        idle_all();
        repeat (4) @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
